// File: rtl/spi_slave_param.sv
// SPI slave, all CPOL/CPHA modes, runtime bit order, oversampled in clk.
// Ports: clk/rst/ena, spi_clk/spi_ss/spi_in/spi_out pins, mode pins,
// tx_data/tx_we/tx_ready/tx_underrun, rx_data/rx_valid/frame_err.
module spi_slave_param #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             spi_clk,
  input  logic             spi_ss,
  input  logic             spi_in,
  output logic             spi_out,
  input  logic             spi_clk_polarity,
  input  logic             spi_clk_phase,
  input  logic             spi_lsb_first,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_we,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] in_sync;
  logic                   clk_d;
  logic                   ss_d;
  logic                   cpol;
  logic                   cpha;
  logic                   lsb;
  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       rx_sh;
  logic [WIDTH-1:0]       tx_sh;
  logic [WIDTH-1:0]       hold;
  logic                   reload;
  logic                   rx_pend;

  logic             clk_s;
  logic             ss_s;
  logic             in_s;
  logic             lead;
  logic             trail;
  logic             smp;
  logic             shf;
  logic             ss_fall;
  logic             ss_rise;
  logic             load;
  logic [WIDTH-1:0] load_word;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign ss_s  = ss_sync[SYNC_STAGES-1];
  assign in_s  = in_sync[SYNC_STAGES-1];

  // Synchronisers keep running under ena=0 so a stalled cycle
  // drops an edge instead of replaying it later.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '0;
      ss_sync  <= '0;
      in_sync  <= '0;
      clk_d    <= 1'b0;
      ss_d     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      ss_sync  <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
      in_sync  <= {in_sync[SYNC_STAGES-2:0], spi_in};
      clk_d    <= clk_s;
      ss_d     <= ss_s;
    end
  end

  assign lead    = (clk_d == cpol) && (clk_s != cpol);
  assign trail   = (clk_d != cpol) && (clk_s == cpol);
  assign smp     = cpha ? trail : lead;
  assign shf     = cpha ? lead : trail;
  assign ss_fall = ss_d && !ss_s;
  assign ss_rise = !ss_d && ss_s;

  // A word load happens at frame start or on the first shift edge
  // after a completed word.
  assign load = ena && ((state == IDLE) ? ss_fall
                                        : (!ss_rise && shf && reload));
  assign load_word = tx_ready ? '0 : hold;

  assign spi_out = (state == ACTIVE) &&
                   (lsb ? tx_sh[0] : tx_sh[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cpol        <= 1'b0;
      cpha        <= 1'b0;
      lsb         <= 1'b0;
      cnt         <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      hold        <= '0;
      reload      <= 1'b0;
      rx_pend     <= 1'b0;
      tx_ready    <= 1'b1;
      tx_underrun <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      if (ena) begin
        if (load) tx_underrun <= tx_ready;
        // A write in the same cycle as a load lands after the load.
        if (tx_we && (tx_ready || load)) begin
          hold     <= tx_data;
          tx_ready <= 1'b0;
        end else if (load) begin
          tx_ready <= 1'b1;
        end

        rx_pend <= 1'b0;
        if (rx_pend) begin
          rx_data  <= rx_sh;
          rx_valid <= 1'b1;
        end

        unique case (state)
          IDLE: begin
            cnt    <= '0;
            rx_sh  <= '0;
            reload <= 1'b0;
            if (ss_fall) begin
              state <= ACTIVE;
              cpol  <= spi_clk_polarity;
              cpha  <= spi_clk_phase;
              lsb   <= spi_lsb_first;
              tx_sh <= load_word;
            end
          end
          ACTIVE: begin
            if (ss_rise) begin
              state     <= IDLE;
              frame_err <= (cnt != '0);
              reload    <= 1'b0;
              cnt       <= '0;
              rx_sh     <= '0;
            end else begin
              if (smp) begin
                rx_sh <= lsb ? {in_s, rx_sh[WIDTH-1:1]}
                             : {rx_sh[WIDTH-2:0], in_s};
                if (cnt == CW'(WIDTH - 1)) begin
                  cnt     <= '0;
                  reload  <= 1'b1;
                  rx_pend <= 1'b1;
                end else begin
                  cnt <= cnt + CW'(1);
                end
              end
              if (shf) begin
                if (reload) begin
                  tx_sh  <= load_word;
                  reload <= 1'b0;
                end else if (cnt != '0) begin
                  tx_sh <= lsb ? (tx_sh >> 1) : (tx_sh << 1);
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
